// File: rtl/regs_wb_arbiter_if.sv
// Write-back arbiter bus bundle: EX and LSU write requests, register-file
// write port and hazard query. slave = arbiter side, master = pipeline side.
interface regs_wb_arbiter_if;
  logic        ex_valid_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        ex_ready_o;
  logic        lsu_valid_i;
  logic [4:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_ready_o;
  logic        reg_wen_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic [4:0]  rs1_raddr_i;
  logic [4:0]  rs2_raddr_i;
  logic        hazard_o;

  modport slave (
    input  ex_valid_i, ex_waddr_i, ex_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  rs1_raddr_i, rs2_raddr_i,
    output ex_ready_o, lsu_ready_o,
    output reg_wen_o, reg_waddr_o, reg_wdata_o, hazard_o
  );

  modport master (
    output ex_valid_i, ex_waddr_i, ex_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output rs1_raddr_i, rs2_raddr_i,
    input  ex_ready_o, lsu_ready_o,
    input  reg_wen_o, reg_waddr_o, reg_wdata_o, hazard_o
  );
endinterface

// File: rtl/regs_wb_arbiter.sv
// Two-source (EX/LSU) register-file write-back arbiter, one buffered entry per source.
// Define WB_ARB_RR_EN for round-robin contention; default is fixed LSU priority.
module regs_wb_arbiter (
  input  logic clk,
  input  logic rst_n,
  regs_wb_arbiter_if.slave bus
);

  typedef enum logic {SRC_LSU = 1'b0, SRC_EX = 1'b1} src_e;

  logic        ex_full, lsu_full;
  logic [4:0]  ex_addr, lsu_addr;
  logic [31:0] ex_data, lsu_data;
  logic        ex_older;
  logic        ex_gnt, lsu_gnt;
  logic        ex_ready, lsu_ready;
  logic        ex_xfer, lsu_xfer;
  logic        ex_hit, lsu_hit;
`ifdef WB_ARB_RR_EN
  src_e        rr_ptr;
`endif

  always_comb begin
    ex_gnt  = 1'b0;
    lsu_gnt = 1'b0;
    if (ex_full && lsu_full) begin
      if (ex_addr == lsu_addr) begin
        ex_gnt  = ex_older;
        lsu_gnt = !ex_older;
      end else begin
`ifdef WB_ARB_RR_EN
        ex_gnt  = (rr_ptr == SRC_EX);
        lsu_gnt = (rr_ptr == SRC_LSU);
`else
        lsu_gnt = 1'b1;
`endif
      end
    end else begin
      ex_gnt  = ex_full;
      lsu_gnt = lsu_full;
    end
  end

  assign ex_ready  = rst_n && (!ex_full  || ex_gnt);
  assign lsu_ready = rst_n && (!lsu_full || lsu_gnt);
  assign ex_xfer   = bus.ex_valid_i  && ex_ready;
  assign lsu_xfer  = bus.lsu_valid_i && lsu_ready;

  assign bus.ex_ready_o  = ex_ready;
  assign bus.lsu_ready_o = lsu_ready;

  always_comb begin
    bus.reg_wen_o   = 1'b0;
    bus.reg_waddr_o = '0;
    bus.reg_wdata_o = '0;
    if (rst_n && lsu_gnt) begin
      bus.reg_wen_o   = 1'b1;
      bus.reg_waddr_o = lsu_addr;
      bus.reg_wdata_o = lsu_data;
    end else if (rst_n && ex_gnt) begin
      bus.reg_wen_o   = 1'b1;
      bus.reg_waddr_o = ex_addr;
      bus.reg_wdata_o = ex_data;
    end
  end

  assign ex_hit  = ex_full &&
                   ((bus.rs1_raddr_i != '0 && ex_addr == bus.rs1_raddr_i) ||
                    (bus.rs2_raddr_i != '0 && ex_addr == bus.rs2_raddr_i));
  assign lsu_hit = lsu_full &&
                   ((bus.rs1_raddr_i != '0 && lsu_addr == bus.rs1_raddr_i) ||
                    (bus.rs2_raddr_i != '0 && lsu_addr == bus.rs2_raddr_i));
  assign bus.hazard_o = rst_n && (ex_hit || lsu_hit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_full  <= 1'b0;
      lsu_full <= 1'b0;
      ex_addr  <= '0;
      lsu_addr <= '0;
      ex_data  <= '0;
      lsu_data <= '0;
      ex_older <= 1'b0;
`ifdef WB_ARB_RR_EN
      rr_ptr   <= SRC_LSU;
`endif
    end else begin
      if (ex_xfer && bus.ex_waddr_i != '0) begin
        ex_full <= 1'b1;
        ex_addr <= bus.ex_waddr_i;
        ex_data <= bus.ex_wdata_i;
      end else if (ex_gnt) begin
        ex_full <= 1'b0;
      end
      if (lsu_xfer && bus.lsu_waddr_i != '0) begin
        lsu_full <= 1'b1;
        lsu_addr <= bus.lsu_waddr_i;
        lsu_data <= bus.lsu_wdata_i;
      end else if (lsu_gnt) begin
        lsu_full <= 1'b0;
      end
      // A surviving (ungranted) EX entry is older than anything LSU loads now;
      // simultaneous fresh loads leave LSU older.
      ex_older <= ex_full && !ex_gnt;
`ifdef WB_ARB_RR_EN
      if (ex_full && lsu_full && ex_addr != lsu_addr)
        rr_ptr <= (rr_ptr == SRC_EX) ? SRC_LSU : SRC_EX;
`endif
    end
  end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Self-checking bench for regs_wb_arbiter: sequence-numbered pending-write model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regs_wb_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regs_wb_arbiter_if bus ();

  regs_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // model state: one pending write per source, stamped with acceptance order
  bit          m_ev, m_lv;
  logic [4:0]  m_ea, m_la;
  logic [31:0] m_ed, m_ld;
  int unsigned m_es, m_ls;
  int unsigned m_seq = 0;
  bit          m_ptr_ex = 1'b0;
  int unsigned n_acc = 0, n_disc = 0, n_wr = 0;

  // model predictions for the current cycle
  bit          x_gnt_e, x_gnt_l, x_exr, x_lsr, x_wen, x_haz;
  logic [4:0]  x_waddr;
  logic [31:0] x_wdata;

  // DUT samples for the current cycle
  logic        s_exr, s_lsr, s_wen, s_haz;
  logic [4:0]  s_waddr;
  logic [31:0] s_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit reads(input logic [4:0] a);
    return (bus.rs1_raddr_i != 0 && a == bus.rs1_raddr_i) ||
           (bus.rs2_raddr_i != 0 && a == bus.rs2_raddr_i);
  endfunction

  function automatic void model_eval();
    x_gnt_e = 1'b0;
    x_gnt_l = 1'b0;
    if (m_ev && m_lv) begin
      if (m_ea == m_la) x_gnt_l = (m_ls < m_es);
`ifdef WB_ARB_RR_EN
      else              x_gnt_l = !m_ptr_ex;
`else
      else              x_gnt_l = 1'b1;
`endif
      x_gnt_e = !x_gnt_l;
    end else begin
      x_gnt_e = m_ev;
      x_gnt_l = m_lv;
    end
    x_exr   = rst_n && (!m_ev || x_gnt_e);
    x_lsr   = rst_n && (!m_lv || x_gnt_l);
    x_wen   = rst_n && (x_gnt_e || x_gnt_l);
    x_waddr = !rst_n ? 5'd0  : x_gnt_l ? m_la : x_gnt_e ? m_ea : 5'd0;
    x_wdata = !rst_n ? 32'd0 : x_gnt_l ? m_ld : x_gnt_e ? m_ed : 32'd0;
    x_haz   = rst_n && ((m_ev && reads(m_ea)) || (m_lv && reads(m_la)));
  endfunction

  function automatic void model_update();
    if (!rst_n) begin
      n_disc += 32'(m_ev) + 32'(m_lv);
      m_ev = 1'b0;
      m_lv = 1'b0;
      m_ptr_ex = 1'b0;
      return;
    end
    if (m_ev && m_lv && m_ea != m_la) m_ptr_ex = !m_ptr_ex;
    if (x_gnt_e) m_ev = 1'b0;
    if (x_gnt_l) m_lv = 1'b0;
    if (bus.lsu_valid_i && x_lsr && bus.lsu_waddr_i != 0) begin
      m_lv = 1'b1; m_la = bus.lsu_waddr_i; m_ld = bus.lsu_wdata_i; m_ls = m_seq++; n_acc++;
    end
    if (bus.ex_valid_i && x_exr && bus.ex_waddr_i != 0) begin
      m_ev = 1'b1; m_ea = bus.ex_waddr_i; m_ed = bus.ex_wdata_i; m_es = m_seq++; n_acc++;
    end
  endfunction

  task automatic cycle();
    @(negedge clk);
    model_eval();
    s_exr = bus.ex_ready_o;   s_lsr = bus.lsu_ready_o;
    s_wen = bus.reg_wen_o;    s_waddr = bus.reg_waddr_o;
    s_wdata = bus.reg_wdata_o; s_haz = bus.hazard_o;
    chk("ex_ready",  32'(s_exr),  32'(x_exr));
    chk("lsu_ready", 32'(s_lsr),  32'(x_lsr));
    chk("reg_wen",   32'(s_wen),  32'(x_wen));
    chk("reg_waddr", 32'(s_waddr), 32'(x_waddr));
    chk("reg_wdata", s_wdata,     x_wdata);
    chk("hazard",    32'(s_haz),  32'(x_haz));
    if (rst_n && s_wen) n_wr++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_in(input bit ev, input logic [4:0] ea, input logic [31:0] ed,
                        input bit lv, input logic [4:0] la, input logic [31:0] ld);
    bus.ex_valid_i = ev;  bus.ex_waddr_i = ea;  bus.ex_wdata_i = ed;
    bus.lsu_valid_i = lv; bus.lsu_waddr_i = la; bus.lsu_wdata_i = ld;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0);
    bus.rs1_raddr_i = '0;
    bus.rs2_raddr_i = '0;

    // reset held
    rst_n = 1'b0;
    cycle();
    cycle();
    chk("rst_ex_ready", 32'(s_exr), 0);
    chk("rst_wen", 32'(s_wen), 0);
    rst_n = 1'b1;
    cycle();
    chk("idle_ex_ready", 32'(s_exr), 1);
    chk("idle_lsu_ready", 32'(s_lsr), 1);

    // single EX write x5=0x1234
    set_in(1, 5'd5, 32'h1234, 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0, 0);
    cycle();
    chk("single_wen", 32'(s_wen), 1);
    chk("single_waddr", 32'(s_waddr), 5);
    chk("single_wdata", s_wdata, 32'h1234);
    chk("single_ex_ready", 32'(s_exr), 1);

    // simultaneous same-register writes: LSU first
    set_in(1, 5'd3, 32'hA, 1, 5'd3, 32'hB);
    cycle();
    set_in(0, 0, 0, 0, 0, 0);
    bus.rs1_raddr_i = 5'd3;
    cycle();
    chk("same_first_data", s_wdata, 32'hB);
    chk("same_first_haz", 32'(s_haz), 1);
    cycle();
    chk("same_second_data", s_wdata, 32'hA);
    chk("same_second_haz", 32'(s_haz), 1);
    cycle();
    chk("same_drained_wen", 32'(s_wen), 0);
    bus.rs1_raddr_i = '0;

    // sustained contention, EX x1 vs LSU x2
    set_in(1, 5'd1, 32'h11, 1, 5'd2, 32'h22);
    cycle();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) set_in(0, 0, 0, 0, 0, 0);
      cycle();
`ifdef WB_ARB_RR_EN
      chk("rr_grant_addr", 32'(s_waddr), (i % 2 == 0) ? 2 : 1);
`else
      chk("fixed_grant_addr", 32'(s_waddr), 2);
      chk("fixed_ex_ready", 32'(s_exr), 0);
`endif
    end
    for (int i = 0; i < 3; i++) cycle();

    // x0 write discarded
    set_in(1, 5'd0, 32'hFFFF, 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0, 0);
    cycle();
    chk("x0_wen", 32'(s_wen), 0);
    chk("x0_haz", 32'(s_haz), 0);

    // reset with both entries full
    set_in(1, 5'd7, 32'h77, 1, 5'd8, 32'h88);
    cycle();
    set_in(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    cycle();
    chk("midrst_wen", 32'(s_wen), 0);
    rst_n = 1'b1;
    cycle();
    chk("postrst_wen", 32'(s_wen), 0);
    chk("postrst_ex_ready", 32'(s_exr), 1);
    chk("postrst_lsu_ready", 32'(s_lsr), 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.ex_valid_i  = ($urandom_range(0, 9) < 6);
      bus.ex_waddr_i  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      bus.ex_wdata_i  = $urandom;
      bus.lsu_valid_i = ($urandom_range(0, 9) < 6);
      bus.lsu_waddr_i = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      bus.lsu_wdata_i = $urandom;
      bus.rs1_raddr_i = 5'($urandom_range(0, 7));
      bus.rs2_raddr_i = 5'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle();
    chk("write_conservation", n_wr, n_acc - n_disc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
